pio_address_shift_register: RTL and testbench

- Upstream neighbour of the LVDA address decode stages.
- Receives the serial PIO/discrete address word from the computer, one bit per bit-time strobe, MSB first.
- Holds the received word as true/complement parallel pairs (the A*DV / A*DVN levels) and asserts the address-valid level ADV for a bounded window.
- Decode modules gate their latches on ADV during that window.

---
 rtl/lvda_pkg.sv | 21 ++
 rtl/pio_bit_counter.sv | 49 ++++
 rtl/pio_address_shift_register.sv | 193 +++++++++++++++++++
 tb/tb_pio_address_shift_register.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lvda_pkg.sv
// lvda_pkg
//   Shared definitions for the LVDA PIO address path.
//   - pio_state_e    : receive/hold FSM states
//   - LVDA_ADDR_BITS : default serial address width
//   - BIT_CNT_W      : width of the serial bit counter
//   - HOLD_CNT_W     : width of the ADV hold counter
package lvda_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_PARITY = 3'd2,
    ST_LOAD   = 3'd3,
    ST_HOLD   = 3'd4
  } pio_state_e;

  localparam int LVDA_ADDR_BITS = 9;
  localparam int BIT_CNT_W      = 4;
  localparam int HOLD_CNT_W     = 4;

endpackage

// File: rtl/pio_bit_counter.sv
// pio_bit_counter
//   Loadable up/down counter with a terminal-count flag. Used once as the
//   serial bit counter (counting up) and once as the ADV hold counter
//   (counting down).
//   Ports:
//     clk_i      clock, rising edge
//     rst_i      synchronous active-high reset (count -> 0)
//     load_i     load load_val_i (wins over en_i)
//     load_val_i value to load
//     en_i       step the counter by one
//     down_i     step direction: 1 = decrement, 0 = increment
//     tc_val_i   terminal value to compare against
//     tc_o       high while the count equals tc_val_i
module pio_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic         down_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = down_i ? (cnt_q - W'(1)) : (cnt_q + W'(1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/pio_address_shift_register.sv
// pio_address_shift_register
//   Receives the serial PIO address word (MSB first, one bit per BSTB),
//   presents it as true/complement parallel levels and raises ADV for
//   HOLD_CYCLES clocks after each good frame.
//   Optional feature macro: LVDA_PIO_PARITY_CHECK_EN adds a trailing
//   odd-parity bit and the PERR pulse; undefined, PERR is tied low.
//   Ports:
//     SIM_CLK  clock, rising edge
//     SIM_RST  synchronous active-high reset
//     ASER     serial data, sampled when BSTB=1
//     BSTB     bit-time strobe
//     AFRM     frame start, qualifies bit 1 together with BSTB
//     ADR      held address, true form (MSB = bit 1)
//     ADRN     complement of ADR
//     ADV      address-valid window
//     PERR     one-cycle parity-error pulse
//   Handshake: there is no back-pressure. A bit is transferred in every
//   cycle where BSTB=1; AFRM&BSTB always restarts the frame from any state
//   that is collecting bits or holding ADV.
module pio_address_shift_register
  import lvda_pkg::*;
#(
  parameter int ADDR_BITS   = LVDA_ADDR_BITS,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 SIM_CLK,
  input  logic                 SIM_RST,
  input  logic                 ASER,
  input  logic                 BSTB,
  input  logic                 AFRM,
  output logic [ADDR_BITS-1:0] ADR,
  output logic [ADDR_BITS-1:0] ADRN,
  output logic                 ADV,
  output logic                 PERR
);

  pio_state_e state_q, state_d;
  logic [ADDR_BITS-1:0] shreg_q, shreg_d;
  logic [ADDR_BITS-1:0] adr_q, adr_d;

  logic frame_start;
  logic bc_load, bc_en, bc_tc;
  logic hc_load, hc_en, hc_tc;

`ifdef LVDA_PIO_PARITY_CHECK_EN
  logic perr_q, perr_d;
  logic parity_ok;
  // Odd parity over the address word plus the parity bit on ASER.
  assign parity_ok = ^{shreg_q, ASER};
`endif

  assign frame_start = AFRM & BSTB;

  // Bit counter: bc_tc marks the last address bit still to come.
  pio_bit_counter #(.W(BIT_CNT_W)) u_bit_cnt (
    .clk_i      (SIM_CLK),
    .rst_i      (SIM_RST),
    .load_i     (bc_load),
    .load_val_i (BIT_CNT_W'(1)),
    .en_i       (bc_en),
    .down_i     (1'b0),
    .tc_val_i   (BIT_CNT_W'(ADDR_BITS - 1)),
    .tc_o       (bc_tc)
  );

  // Hold counter: leaving HOLD as it steps from 1 to 0 gives exactly
  // HOLD_CYCLES cycles of ADV.
  pio_bit_counter #(.W(HOLD_CNT_W)) u_hold_cnt (
    .clk_i      (SIM_CLK),
    .rst_i      (SIM_RST),
    .load_i     (hc_load),
    .load_val_i (HOLD_CNT_W'(HOLD_CYCLES)),
    .en_i       (hc_en),
    .down_i     (1'b1),
    .tc_val_i   (HOLD_CNT_W'(1)),
    .tc_o       (hc_tc)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    adr_d   = adr_q;
    bc_load = 1'b0;
    bc_en   = 1'b0;
    hc_load = 1'b0;
    hc_en   = 1'b0;
`ifdef LVDA_PIO_PARITY_CHECK_EN
    perr_d  = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          shreg_d    = '0;
          shreg_d[0] = ASER;
          bc_load    = 1'b1;
          state_d    = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (frame_start) begin
          shreg_d    = '0;
          shreg_d[0] = ASER;
          bc_load    = 1'b1;
        end else if (BSTB) begin
          shreg_d = {shreg_q[ADDR_BITS-2:0], ASER};
          bc_en   = 1'b1;
          if (bc_tc) begin
`ifdef LVDA_PIO_PARITY_CHECK_EN
            state_d = ST_PARITY;
`else
            state_d = ST_LOAD;
`endif
          end
        end
      end

      ST_PARITY: begin
`ifdef LVDA_PIO_PARITY_CHECK_EN
        if (frame_start) begin
          shreg_d    = '0;
          shreg_d[0] = ASER;
          bc_load    = 1'b1;
          state_d    = ST_SHIFT;
        end else if (BSTB) begin
          if (parity_ok) begin
            state_d = ST_LOAD;
          end else begin
            perr_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end

      ST_LOAD: begin
        adr_d   = shreg_q;
        hc_load = 1'b1;
        state_d = ST_HOLD;
      end

      ST_HOLD: begin
        if (frame_start) begin
          shreg_d    = '0;
          shreg_d[0] = ASER;
          bc_load    = 1'b1;
          state_d    = ST_SHIFT;
        end else begin
          hc_en = 1'b1;
          if (hc_tc) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      adr_q   <= '0;
`ifdef LVDA_PIO_PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      adr_q   <= adr_d;
`ifdef LVDA_PIO_PARITY_CHECK_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign ADR  = adr_q;
  assign ADRN = ~adr_q;
  // ADV is a pure decode of the state register, so it changes on the same
  // edge as ADR.
  assign ADV  = (state_q == ST_HOLD);

`ifdef LVDA_PIO_PARITY_CHECK_EN
  assign PERR = perr_q;
`else
  assign PERR = 1'b0;
`endif

endmodule

// File: tb/tb_pio_address_shift_register.sv
module tb_pio_address_shift_register;

  logic       SIM_CLK = 1'b0;
  logic       SIM_RST = 1'b1;
  logic       ASER    = 1'b0;
  logic       BSTB    = 1'b0;
  logic       AFRM    = 1'b0;
  logic [8:0] ADR;
  logic [8:0] ADRN;
  logic       ADV;
  logic       PERR;

  int errors = 0;
  int checks = 0;

  pio_address_shift_register #(.ADDR_BITS(9), .HOLD_CYCLES(4)) dut (
    .SIM_CLK (SIM_CLK),
    .SIM_RST (SIM_RST),
    .ASER    (ASER),
    .BSTB    (BSTB),
    .AFRM    (AFRM),
    .ADR     (ADR),
    .ADRN    (ADRN),
    .ADV     (ADV),
    .PERR    (PERR)
  );

  // ---------------- clock / reset ----------------
  always #5 SIM_CLK = ~SIM_CLK;

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge SIM_CLK);
    #1;
  endtask

  // ---------------- driver ----------------
  // Sends n bits of data MSB first; AFRM on the first bit when afrm_first.
  // Returns just after the edge that sampled the last bit.
  task automatic send_bits(input logic [15:0] data, input int n,
                           input bit afrm_first, input int gap);
    for (int i = 0; i < n; i++) begin
      BSTB = 1'b1;
      AFRM = (i == 0) && afrm_first;
      ASER = data[n-1-i];
      tick();
      BSTB = 1'b0;
      AFRM = 1'b0;
      ASER = 1'b0;
      if (i != n - 1) repeat (gap) tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    SIM_RST = 1'b1;
    tick();
    tick();
    checks++; if (ADR !== 9'h000) begin errors++; $display("FAIL reset_adr got=%h exp=%h", ADR, 9'h000); end
    checks++; if (ADRN !== 9'h1FF) begin errors++; $display("FAIL reset_adrn got=%h exp=%h", ADRN, 9'h1FF); end
    checks++; if (ADV !== 1'b0) begin errors++; $display("FAIL reset_adv got=%b exp=0", ADV); end
    checks++; if (PERR !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", PERR); end
    SIM_RST = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame();
    send_bits(16'h0165, 9, 1'b1, 1);
    // LOAD cycle: nothing visible yet.
    checks++; if (ADV !== 1'b0) begin errors++; $display("FAIL basic_adv_load got=%b exp=0", ADV); end
    checks++; if (ADR !== 9'h000) begin errors++; $display("FAIL basic_adr_load got=%h exp=%h", ADR, 9'h000); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (ADV !== 1'b1) begin errors++; $display("FAIL basic_adv_win%0d got=%b exp=1", k, ADV); end
      checks++; if (ADR !== 9'h165) begin errors++; $display("FAIL basic_adr%0d got=%h exp=%h", k, ADR, 9'h165); end
      checks++; if (ADRN !== 9'h09A) begin errors++; $display("FAIL basic_adrn%0d got=%h exp=%h", k, ADRN, 9'h09A); end
      checks++; if (PERR !== 1'b0) begin errors++; $display("FAIL basic_perr%0d got=%b exp=0", k, PERR); end
    end
    tick();
    checks++; if (ADV !== 1'b0) begin errors++; $display("FAIL basic_adv_end got=%b exp=0", ADV); end
    checks++; if (ADR !== 9'h165) begin errors++; $display("FAIL basic_adr_persist got=%h exp=%h", ADR, 9'h165); end
  endtask

  // BSTB without AFRM while idle must be ignored.
  task automatic test_idle_strobes();
    int adv_seen;
    adv_seen = 0;
    send_bits(16'h0000, 9, 1'b0, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ADV === 1'b1) adv_seen++;
    end
    checks++; if (adv_seen !== 0) begin errors++; $display("FAIL idle_adv_count got=%0d exp=0", adv_seen); end
    checks++; if (ADR !== 9'h165) begin errors++; $display("FAIL idle_adr got=%h exp=%h", ADR, 9'h165); end
  endtask

`ifdef LVDA_PIO_PARITY_CHECK_EN
  task automatic test_parity();
    // Bad frame 0x0F0 (four ones) with parity 0: even total -> error.
    send_bits(16'h01E0, 10, 1'b1, 1);
    checks++; if (PERR !== 1'b1) begin errors++; $display("FAIL par_perr_pulse got=%b exp=1", PERR); end
    checks++; if (ADV !== 1'b0) begin errors++; $display("FAIL par_adv_bad got=%b exp=0", ADV); end
    tick();
    checks++; if (PERR !== 1'b0) begin errors++; $display("FAIL par_perr_clear got=%b exp=0", PERR); end
    checks++; if (ADR !== 9'h165) begin errors++; $display("FAIL par_adr_kept got=%h exp=%h", ADR, 9'h165); end
    // 0x165 (five ones) with parity 0: odd total -> loads.
    send_bits(16'h02CA, 10, 1'b1, 1);
    checks++; if (PERR !== 1'b0) begin errors++; $display("FAIL par_perr_good got=%b exp=0", PERR); end
    tick();
    checks++; if (ADV !== 1'b1) begin errors++; $display("FAIL par_adv_good got=%b exp=1", ADV); end
    checks++; if (ADR !== 9'h165) begin errors++; $display("FAIL par_adr_good got=%h exp=%h", ADR, 9'h165); end
    repeat (4) tick();
    // 0x165 with parity 1: even total -> error, no window.
    send_bits(16'h02CB, 10, 1'b1, 1);
    checks++; if (PERR !== 1'b1) begin errors++; $display("FAIL par_perr_165 got=%b exp=1", PERR); end
    tick();
    checks++; if (ADV !== 1'b0) begin errors++; $display("FAIL par_adv_165 got=%b exp=0", ADV); end
  endtask
`endif

  task automatic test_abort_shift();
    int adv_cnt;
    adv_cnt = 0;
    send_bits(16'h001F, 5, 1'b1, 1);
    tick();
    checks++; if (ADV !== 1'b0) begin errors++; $display("FAIL abort_adv_mid got=%b exp=0", ADV); end
    send_bits(16'h00F0, 9, 1'b1, 1);
    checks++; if (ADR !== 9'h165) begin errors++; $display("FAIL abort_adr_load got=%h exp=%h", ADR, 9'h165); end
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ADV === 1'b1) adv_cnt++;
      if (ADV === 1'b1 && ADR !== 9'h0F0) begin
        errors++; $display("FAIL abort_adr_win got=%h exp=%h", ADR, 9'h0F0);
      end
    end
    checks++; if (adv_cnt !== 4) begin errors++; $display("FAIL abort_adv_count got=%0d exp=4", adv_cnt); end
    checks++; if (ADR !== 9'h0F0) begin errors++; $display("FAIL abort_adr got=%h exp=%h", ADR, 9'h0F0); end
  endtask

  task automatic test_abort_hold();
    int adv_cnt;
    adv_cnt = 0;
    send_bits(16'h00AA, 9, 1'b1, 1);
    tick();
    tick();
    checks++; if (ADV !== 1'b1) begin errors++; $display("FAIL hold_adv_2nd got=%b exp=1", ADV); end
    // New frame 0x133: bit 1 is '1', sent on the 2nd ADV cycle.
    send_bits(16'h0001, 1, 1'b1, 0);
    checks++; if (ADV !== 1'b0) begin errors++; $display("FAIL hold_adv_drop got=%b exp=0", ADV); end
    checks++; if (ADR !== 9'h0AA) begin errors++; $display("FAIL hold_adr_kept got=%h exp=%h", ADR, 9'h0AA); end
    tick();
    send_bits(16'h0033, 8, 1'b0, 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ADV === 1'b1) adv_cnt++;
    end
    checks++; if (adv_cnt !== 4) begin errors++; $display("FAIL hold_adv_count got=%0d exp=4", adv_cnt); end
    checks++; if (ADR !== 9'h133) begin errors++; $display("FAIL hold_adr_new got=%h exp=%h", ADR, 9'h133); end
  endtask

  task automatic test_reset_mid();
    // Reset mid-SHIFT.
    send_bits(16'h000F, 4, 1'b1, 1);
    SIM_RST = 1'b1;
    tick();
    SIM_RST = 1'b0;
    checks++; if (ADR !== 9'h000) begin errors++; $display("FAIL rst_shift_adr got=%h exp=%h", ADR, 9'h000); end
    checks++; if (ADRN !== 9'h1FF) begin errors++; $display("FAIL rst_shift_adrn got=%h exp=%h", ADRN, 9'h1FF); end
    checks++; if (ADV !== 1'b0) begin errors++; $display("FAIL rst_shift_adv got=%b exp=0", ADV); end
    tick();
    send_bits(16'h0055, 9, 1'b1, 1);
    tick();
    checks++; if (ADR !== 9'h055) begin errors++; $display("FAIL rst_shift_next got=%h exp=%h", ADR, 9'h055); end
    checks++; if (ADV !== 1'b1) begin errors++; $display("FAIL rst_shift_next_adv got=%b exp=1", ADV); end
    // Reset mid-HOLD.
    SIM_RST = 1'b1;
    tick();
    SIM_RST = 1'b0;
    checks++; if (ADR !== 9'h000) begin errors++; $display("FAIL rst_hold_adr got=%h exp=%h", ADR, 9'h000); end
    checks++; if (ADRN !== 9'h1FF) begin errors++; $display("FAIL rst_hold_adrn got=%h exp=%h", ADRN, 9'h1FF); end
    checks++; if (ADV !== 1'b0) begin errors++; $display("FAIL rst_hold_adv got=%b exp=0", ADV); end
    tick();
    send_bits(16'h01C3, 9, 1'b1, 1);
    tick();
    checks++; if (ADR !== 9'h1C3) begin errors++; $display("FAIL rst_hold_next got=%h exp=%h", ADR, 9'h1C3); end
    checks++; if (ADRN !== 9'h03C) begin errors++; $display("FAIL rst_hold_next_n got=%h exp=%h", ADRN, 9'h03C); end
    repeat (4) tick();
  endtask

  // BSTB held high for 9 consecutive cycles after an AFRM pulse.
  task automatic test_back_to_back();
    int adv_cnt;
    adv_cnt = 0;
    send_bits(16'h00E7, 9, 1'b1, 0);
    checks++; if (ADV !== 1'b0) begin errors++; $display("FAIL b2b_adv_load got=%b exp=0", ADV); end
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ADV === 1'b1) adv_cnt++;
    end
    checks++; if (adv_cnt !== 4) begin errors++; $display("FAIL b2b_adv_count got=%0d exp=4", adv_cnt); end
    checks++; if (ADR !== 9'h0E7) begin errors++; $display("FAIL b2b_adr got=%h exp=%h", ADR, 9'h0E7); end
    checks++; if (ADRN !== 9'h118) begin errors++; $display("FAIL b2b_adrn got=%h exp=%h", ADRN, 9'h118); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic_frame();
    test_idle_strobes();
`ifdef LVDA_PIO_PARITY_CHECK_EN
    test_parity();
`endif
    test_abort_shift();
    test_abort_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
